// File: rtl/dm_arb.sv
// Two-requester arbiter for the single-port data memory: CPU priority with host aging.
// Define DM_ARB_RR_EN to replace aging with strict alternation when both request.
module dm_arb #(
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req0_i,
  input  logic          req1_i,
  input  logic          we0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          gnt0_o,
  output logic          gnt1_o,
  output logic          rvalid0_o,
  output logic          rvalid1_o,
  output logic [DW-1:0] rdata_o,
  output logic [AW-1:0] dm_addr_o,
  output logic [DW-1:0] dm_wdata_o,
  output logic          dm_we_o,
  input  logic [DW-1:0] dm_rdata_i
);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;  // 1 = host owns the current access
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic          dm_we_q, dm_we_d;
  logic [AW-1:0] dm_addr_q, dm_addr_d;
  logic [DW-1:0] dm_wdata_q, dm_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          host_wins;

`ifdef DM_ARB_RR_EN
  logic last_owner_q, last_owner_d;

  assign host_wins = req1_i & (~req0_i | ~last_owner_q);
`else
  localparam logic [3:0] MaxWaitCnt = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;

  assign host_wins = req1_i & (~req0_i | (wait_cnt_q == MaxWaitCnt));
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    dm_we_d    = 1'b0;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    rdata_d    = rdata_q;
`ifdef DM_ARB_RR_EN
    last_owner_d = last_owner_q;
`else
    wait_cnt_d   = wait_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req0_i || req1_i) begin
          state_d    = StAccess;
          owner_d    = host_wins;
          gnt0_d     = ~host_wins;
          gnt1_d     = host_wins;
          dm_we_d    = host_wins ? we1_i    : we0_i;
          dm_addr_d  = host_wins ? addr1_i  : addr0_i;
          dm_wdata_d = host_wins ? wdata1_i : wdata0_i;
`ifdef DM_ARB_RR_EN
          last_owner_d = host_wins;
`else
          if (host_wins) begin
            wait_cnt_d = 4'd0;
          end else if (req1_i && (wait_cnt_q != MaxWaitCnt)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
`endif
        end
      end
      StAccess: begin
        state_d   = StIdle;
        rvalid0_d = ~owner_q;
        rvalid1_d = owner_q;
        if (!dm_we_q) begin
          rdata_d = dm_rdata_i;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      rdata_q    <= rdata_d;
    end
  end

`ifdef DM_ARB_RR_EN
  // Reset to host so the CPU takes the first contested slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_owner_q <= 1'b1;
    else         last_owner_q <= last_owner_d;
  end
`else
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wait_cnt_q <= 4'd0;
    else         wait_cnt_q <= wait_cnt_d;
  end
`endif

  assign gnt0_o     = gnt0_q;
  assign gnt1_o     = gnt1_q;
  assign rvalid0_o  = rvalid0_q;
  assign rvalid1_o  = rvalid1_q;
  assign rdata_o    = rdata_q;
  assign dm_addr_o  = dm_addr_q;
  assign dm_wdata_o = dm_wdata_q;
  assign dm_we_o    = dm_we_q;

endmodule

// File: tb/tb_dm_arb.sv
// Directed bench for dm_arb with a small combinational-read memory model on the dm port.
module tb_dm_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, dm_we;
  logic [31:0] rdata, dm_wdata, dm_rdata;
  logic [15:0] dm_addr;
  logic [31:0] mem [256];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dm_arb dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req0_i     (req0),
    .req1_i     (req1),
    .we0_i      (we0),
    .we1_i      (we1),
    .addr0_i    (addr0),
    .addr1_i    (addr1),
    .wdata0_i   (wdata0),
    .wdata1_i   (wdata1),
    .gnt0_o     (gnt0),
    .gnt1_o     (gnt1),
    .rvalid0_o  (rvalid0),
    .rvalid1_o  (rvalid1),
    .rdata_o    (rdata),
    .dm_addr_o  (dm_addr),
    .dm_wdata_o (dm_wdata),
    .dm_we_o    (dm_we),
    .dm_rdata_i (dm_rdata)
  );

  assign dm_rdata = mem[dm_addr[7:0]];

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr[7:0]] <= dm_wdata;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One access from a single requester; address is corrupted during ACCESS to prove latching.
  task automatic access(input bit host, input bit we, input logic [15:0] a, input logic [31:0] d,
                        input bit chk_rd, input logic [31:0] exp_rd);
    @(negedge clk);
    if (host) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    @(negedge clk);
    check("gnt", {gnt0, gnt1}, host ? 2'b01 : 2'b10);
    check("dm_we", dm_we, we);
    check("dm_addr", dm_addr, a);
    if (we) check("dm_wdata", dm_wdata, d);
    req0 = 1'b0; req1 = 1'b0;
    addr0 = ~a; addr1 = ~a;
    #1 check("dm_addr_held", dm_addr, a);
    @(negedge clk);
    check("rvalid", {rvalid0, rvalid1, gnt0, gnt1, dm_we}, host ? 5'b01000 : 5'b10000);
    if (chk_rd) check("rdata", rdata, exp_rd);
  endtask

  initial begin
    bit exp_order [10];
    int ngnt;

`ifdef DM_ARB_RR_EN
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h20] = 32'h1234_5678;
    mem[8'h40] = 32'hA5A5_0F0F;

    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    rst_n = 1'b0;
    #12;
    check("reset_outs", {gnt0, gnt1, rvalid0, rvalid1, dm_we, dm_addr, dm_wdata, rdata}, '0);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outs", {gnt0, gnt1, rvalid0, rvalid1, dm_we, dm_addr, dm_wdata, rdata}, '0);
    end

    // CPU write then read back
    access(1'b0, 1'b1, 16'h0010, 32'hDEAD_BEEF, 1'b1, 32'h0);
    access(1'b0, 1'b0, 16'h0010, 32'h0, 1'b1, 32'hDEAD_BEEF);

    // Host-only read of preloaded word
    access(1'b1, 1'b0, 16'h0020, 32'h0, 1'b1, 32'h1234_5678);

    // Both requesting continuously
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0020;
    ngnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("gnt_exclusive", gnt0 & gnt1, 1'b0);
      if (gnt0 || gnt1) begin
        if (ngnt < 10) check($sformatf("order[%0d]", ngnt), gnt1, exp_order[ngnt]);
        ngnt++;
      end
    end
    check("grant_count", ngnt, 10);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("contest_idle", {gnt0, gnt1, dm_we}, 3'b000);

    // Reset during a CPU write ACCESS
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0030; wdata0 = 32'hCAFE_F00D;
    @(negedge clk);
    check("rst_pre_we", {gnt0, dm_we}, 2'b11);
    req0 = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("rst_async", {gnt0, gnt1, dm_we, dm_addr}, '0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_no_rvalid", {rvalid0, rvalid1, gnt0, gnt1, dm_we}, 5'b00000);
    access(1'b0, 1'b0, 16'h0030, 32'h0, 1'b1, 32'h0);

    // Address changed during ACCESS has no effect on data read
    access(1'b0, 1'b0, 16'h0040, 32'h0, 1'b1, 32'hA5A5_0F0F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
